// File: rtl/ext_com_pkg.sv
// Shared definitions for the external-communication UART blocks:
// sender FSM states, receiver states, the acknowledgement value and baud helper.
package ext_com_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        WAIT_ACK
    } sender_state_t;

    typedef enum logic [1:0] {
        RX_HUNT,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] UART_ACK = 8'b11001100;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_ack_sender_if.sv
// Controller-side handshake of the ACK sender: byte/send request in,
// ready/done/fail/attempt status out.
interface uart_ack_sender_if #(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned RETRANSMIT_COUNT = 5
);
    localparam int unsigned ATTEMPT_W = $clog2(RETRANSMIT_COUNT + 2);

    logic [DATA_WIDTH-1:0] data_in;
    logic                  send;
    logic                  ready;
    logic                  done;
    logic                  fail;
    logic [ATTEMPT_W-1:0]  attempt;

    modport master (
        output data_in, send,
        input  ready, done, fail, attempt
    );

    modport slave (
        input  data_in, send,
        output ready, done, fail, attempt
    );

endinterface

// File: rtl/uart_ack_sender_byte_rx.sv
// UART byte receiver: 2-flop rx synchroniser plus an enable-gated deserialiser
// that pulses byte_valid only for frames with a good stop bit.
module uart_byte_rx
    import ext_com_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  rx,
    output logic                  byte_valid,
    output logic [DATA_WIDTH-1:0] byte_data
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    logic [1:0]            sync_q;
    logic                  prev_q;
    logic                  rx_s;
    rx_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  valid_q, valid_d;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        valid_d = 1'b0;
        if (!en) begin
            state_d = RX_HUNT;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                RX_HUNT: begin
                    if (prev_q && !rx_s) begin
                        state_d = RX_START;
                        cnt_d   = '0;
                    end
                end
                // Start bit must still be low at its midpoint, otherwise it was a glitch.
                RX_START: begin
                    if (cnt_q == HALF_BIT) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = rx_s ? RX_HUNT : RX_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == LAST_CLK) begin
                        cnt_d   = '0;
                        shreg_d = {rx_s, shreg_q[DATA_WIDTH-1:1]};
                        if (idx_q == LAST_IDX) begin
                            state_d = RX_STOP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == LAST_CLK) begin
                        cnt_d   = '0;
                        valid_d = rx_s;
                        state_d = RX_HUNT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = RX_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            state_q <= RX_HUNT;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            prev_q  <= sync_q[1];
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            valid_q <= valid_d;
        end
    end

    assign byte_valid = valid_q;
    assign byte_data  = shreg_q;

endmodule

// File: rtl/uart_ack_sender.sv
// UART transmit stage with acknowledgement: sends a byte, waits for ACK_BYTE
// on rx, retransmits on timeout and reports done/fail as one-cycle pulses.
module uart_ack_sender
    import ext_com_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned CLK_FREQ         = 50_000_000,
    parameter int unsigned BAUD_RATE        = 230400,
    parameter int unsigned RETRANSMIT_COUNT = 5,
    parameter int unsigned ACK_TIMEOUT      = 1,
    parameter logic [DATA_WIDTH-1:0] ACK_BYTE = UART_ACK
) (
    input  logic               clk,
    input  logic               rst,
    uart_ack_sender_if.slave   ctrl,
    output logic               tx,
    input  logic               rx
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned TIMEOUT_CLKS = CLK_FREQ / 1000 * ACK_TIMEOUT;
    localparam int unsigned ATT_W = $clog2(RETRANSMIT_COUNT + 2);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS);

    sender_state_t         state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bitclk_q, bitclk_d;
    logic [IDX_W-1:0]      bitidx_q, bitidx_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [ATT_W-1:0]      attempt_q, attempt_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  fail_q, fail_d;

    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  ack_hit;
    logic                  bit_end;

    uart_byte_rx #(
        .DATA_WIDTH   (DATA_WIDTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .en         (state_q == WAIT_ACK),
        .rx         (rx),
        .byte_valid (rx_valid),
        .byte_data  (rx_data)
    );

    assign ack_hit = rx_valid && (rx_data == ACK_BYTE);
    assign bit_end = (bitclk_q == CNT_W'(CLKS_PER_BIT - 1));

    // tx is registered from the next-state decision so each bit lasts exactly CLKS_PER_BIT.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        shift_d   = shift_q;
        bitclk_d  = bitclk_q;
        bitidx_d  = bitidx_q;
        tmo_d     = tmo_q;
        attempt_d = attempt_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        fail_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl.send) begin
                    data_d    = ctrl.data_in;
                    shift_d   = ctrl.data_in;
                    attempt_d = ATT_W'(1);
                    bitclk_d  = '0;
                    tx_d      = 1'b0;
                    state_d   = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    bitclk_d = '0;
                    bitidx_d = '0;
                    tx_d     = shift_q[0];
                    state_d  = TX_DATA;
                end else begin
                    bitclk_d = bitclk_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    bitclk_d = '0;
                    if (bitidx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        shift_d  = shift_q >> 1;
                        tx_d     = shift_q[1];
                        bitidx_d = bitidx_q + 1'b1;
                    end
                end else begin
                    bitclk_d = bitclk_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    bitclk_d = '0;
                    tmo_d    = '0;
                    state_d  = WAIT_ACK;
                end else begin
                    bitclk_d = bitclk_q + 1'b1;
                end
            end
            WAIT_ACK: begin
                tmo_d = tmo_q + 1'b1;
                if (ack_hit) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tmo_q == TMO_W'(TIMEOUT_CLKS - 1)) begin
                    if (attempt_q <= ATT_W'(RETRANSMIT_COUNT)) begin
                        attempt_d = attempt_q + 1'b1;
                        shift_d   = data_q;
                        bitclk_d  = '0;
                        tx_d      = 1'b0;
                        state_d   = TX_START;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            shift_q   <= '0;
            bitclk_q  <= '0;
            bitidx_q  <= '0;
            tmo_q     <= '0;
            attempt_q <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            shift_q   <= shift_d;
            bitclk_q  <= bitclk_d;
            bitidx_q  <= bitidx_d;
            tmo_q     <= tmo_d;
            attempt_q <= attempt_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
        end
    end

    assign tx           = tx_q;
    assign ctrl.ready   = (state_q == IDLE);
    assign ctrl.done    = done_q;
    assign ctrl.fail    = fail_q;
    assign ctrl.attempt = attempt_q;

endmodule

// File: tb/tb_uart_ack_sender.sv
// Bench for uart_ack_sender: frame-level model of tx/ready/attempt/fail/done
// checked every cycle, plus directed scenarios with literal expectations.
module tb_uart_ack_sender;

    localparam int CPB   = 217;
    localparam int FRAME = 10 * CPB;
    localparam int TMO   = 5000;
    localparam int RC    = 5;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic tx;

    always #10 clk = ~clk;

    uart_ack_sender_if #(.DATA_WIDTH(8), .RETRANSMIT_COUNT(RC)) bus ();

    // CLK_FREQ/BAUD chosen so CLKS_PER_BIT stays 217 while TIMEOUT_CLKS becomes 5000.
    uart_ack_sender #(
        .DATA_WIDTH       (8),
        .CLK_FREQ         (5_000_000),
        .BAUD_RATE        (23040),
        .RETRANSMIT_COUNT (RC),
        .ACK_TIMEOUT      (1),
        .ACK_BYTE         (8'hCC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus),
        .tx   (tx),
        .rx   (rx)
    );

    int cmp_n = 0;
    int err_n = 0;

    task automatic summary_and_finish();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            if (err_n >= 200) summary_and_finish();
        end
    endtask

    // Inputs as the DUT saw them at the last rising edge.
    logic       rst_s, send_s;
    logic [7:0] data_s;
    always @(posedge clk) begin
        rst_s  <= rst;
        send_s <= bus.send;
        data_s <= bus.data_in;
    end

    bit chk_en  = 0;
    bit ack_win = 0;
    int done_n  = 0;
    int fail_n  = 0;

    // Model: phase 0 idle, 1 sending a frame (t = cycles into frame), 2 waiting for ACK.
    int         ph    = 0;
    int         t     = 0;
    int         m_att = 0;
    logic [7:0] m_data;
    initial forever begin
        logic [9:0] fb;
        logic       exp_tx;
        bit         exp_fail;
        bit         done_ok;
        @(negedge clk);
        if (chk_en) begin
            exp_fail = 0;
            done_ok  = 0;
            if (rst_s) begin
                ph    = 0;
                m_att = 0;
            end else begin
                case (ph)
                    0: if (send_s) begin
                        ph = 1; t = 0; m_att = 1; m_data = data_s;
                    end
                    1: begin
                        t++;
                        if (t == FRAME) begin ph = 2; t = 0; end
                    end
                    default: begin
                        t++;
                        if (ack_win && bus.done === 1'b1) begin
                            done_ok = 1; ph = 0;
                        end else if (t == TMO) begin
                            if (m_att <= RC) begin
                                m_att++; ph = 1; t = 0;
                            end else begin
                                exp_fail = 1; ph = 0;
                            end
                        end
                    end
                endcase
            end
            fb     = {1'b1, m_data, 1'b0};
            exp_tx = (ph == 1) ? fb[t / CPB] : 1'b1;
            check("tx", tx, exp_tx);
            check("ready", bus.ready, (ph == 0));
            check("attempt", bus.attempt, m_att);
            check("fail", bus.fail, exp_fail);
            check("done", bus.done, done_ok);
            if (bus.done === 1'b1) done_n++;
            if (bus.fail === 1'b1) fail_n++;
        end
    end

    // Frame capture: mid-bit samples of each tx frame, bit 0 = start bit.
    int         frames = 0;
    logic [9:0] last_frame = '0;
    logic [9:0] prev_frame = '0;
    initial forever begin
        logic       prev_tx;
        logic [9:0] cur;
        int         cnt;
        bit         cap;
        int         idx;
        @(negedge clk);
        if (rst_s === 1'b1) begin
            cap = 0;
        end else if (!cap && prev_tx === 1'b1 && tx === 1'b0) begin
            cap = 1;
            cnt = 0;
        end
        if (cap) begin
            if (cnt >= CPB / 2 && (cnt - CPB / 2) % CPB == 0) begin
                idx      = (cnt - CPB / 2) / CPB;
                cur[idx] = tx;
                if (idx == 9) begin
                    prev_frame = last_frame;
                    last_frame = cur;
                    frames++;
                    cap = 0;
                end
            end
            cnt++;
        end
        prev_tx = tx;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        bus.data_in = d;
        bus.send    = 1'b1;
        tick(1);
        bus.send    = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b, input bit is_ack);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx      = 1'b1;
        ack_win = is_ack;
        tick(CPB);
        ack_win = 0;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (bus.ready !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check("wait_ready", bus.ready, 1);
    endtask

    initial begin
        repeat (120000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        err_n++;
        summary_and_finish();
    end

    initial begin
        int f0, d0, fl0;
        rst         = 1'b1;
        rx          = 1'b1;
        bus.send    = 1'b0;
        bus.data_in = '0;
        tick(3);
        chk_en = 1;
        check("rst_tx", tx, 1);
        check("rst_ready", bus.ready, 1);
        check("rst_attempt", bus.attempt, 0);
        check("rst_done", bus.done, 0);
        check("rst_fail", bus.fail, 0);
        rst = 1'b0;
        tick(1);

        // Single byte, prompt ACK
        f0 = frames; d0 = done_n;
        send_byte(8'h05);
        tick(FRAME - 1 + 100);
        rx_byte(8'hCC, 1);
        tick(5);
        check("s1_frame", last_frame, 10'b1000001010);
        check("s1_frames", frames - f0, 1);
        check("s1_done", done_n - d0, 1);
        check("s1_attempt", bus.attempt, 1);
        check("s1_ready", bus.ready, 1);

        // Wrong byte then ACK
        f0 = frames; d0 = done_n;
        send_byte(8'h5A);
        tick(FRAME - 1 + 100);
        rx_byte(8'h3B, 0);
        tick(20);
        rx_byte(8'hCC, 1);
        tick(5);
        check("s2_frame", last_frame, 10'b1010110100);
        check("s2_frames", frames - f0, 1);
        check("s2_done", done_n - d0, 1);
        check("s2_attempt", bus.attempt, 1);

        // Retry then success
        f0 = frames; d0 = done_n;
        send_byte(8'h96);
        tick(FRAME - 1 + TMO + FRAME + 100);
        rx_byte(8'hCC, 1);
        tick(5);
        check("s3_frames", frames - f0, 2);
        check("s3_frame1", prev_frame, 10'b1100101100);
        check("s3_frame2", last_frame, 10'b1100101100);
        check("s3_done", done_n - d0, 1);
        check("s3_attempt", bus.attempt, 2);

        // Exhaustion
        f0 = frames; d0 = done_n; fl0 = fail_n;
        send_byte(8'h3C);
        wait_ready(6 * (FRAME + TMO) + 50);
        tick(5);
        check("s4_frames", frames - f0, 6);
        check("s4_fail", fail_n - fl0, 1);
        check("s4_done", done_n - d0, 0);
        check("s4_attempt", bus.attempt, 6);

        // Busy send ignored, then reset mid-frame
        send_byte(8'hA5);
        tick(3 * CPB);
        send_byte(8'h11);
        tick(300);
        rst = 1'b1;
        tick(1);
        check("s5_rst_tx", tx, 1);
        check("s5_rst_ready", bus.ready, 1);
        check("s5_rst_attempt", bus.attempt, 0);
        rst = 1'b0;
        tick(1);
        f0 = frames; d0 = done_n;
        send_byte(8'h5A);
        tick(FRAME - 1 + 100);
        rx_byte(8'hCC, 1);
        tick(5);
        check("s5_frame", last_frame, 10'b1010110100);
        check("s5_frames", frames - f0, 1);
        check("s5_done", done_n - d0, 1);

        // rx activity during TX ignored; glitch rejected in WAIT_ACK
        f0 = frames; d0 = done_n;
        send_byte(8'hC3);
        tick(10);
        rx_byte(8'hCC, 0);
        tick(100);
        rx = 1'b0;
        tick(50);
        rx = 1'b1;
        tick(300);
        check("s6_no_early_done", done_n - d0, 0);
        rx_byte(8'hCC, 1);
        tick(5);
        check("s6_frame", last_frame, 10'b1110000110);
        check("s6_frames", frames - f0, 1);
        check("s6_done", done_n - d0, 1);
        check("s6_attempt", bus.attempt, 1);

        summary_and_finish();
    end

endmodule

// File: doc/uart_ack_sender.md
Name: uart_ack_sender

Overview:
- External-communication transmit stage with acknowledgement handling.
- Takes a byte from the external-communication controller and serialises it on the UART tx line (GPIO send_data wire).
- Then listens on the rx line (GPIO send_ack wire) for the acknowledgement byte, retransmitting on timeout.
- Reports success or final failure back to the controller with a one-cycle pulse.

Parameters:
- DATA_WIDTH, 8, UART word width in bits.
- CLK_FREQ, 50_000_000, clock frequency in Hz.
- BAUD_RATE, 230400, UART bit rate.
- RETRANSMIT_COUNT, 5, retransmissions allowed after the first attempt.
- ACK_TIMEOUT, 1, acknowledgement wait per attempt, in milliseconds.
- ACK_BYTE, 8'b11001100, acknowledgement value.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- data_in, input, DATA_WIDTH, byte to send; captured on an accepted send.
- send, input, 1, start request; accepted only when ready=1.
- ready, output, 1, idle and able to accept send.
- tx, output, 1, UART transmit line; idles high.
- rx, input, 1, asynchronous UART receive line for the acknowledgement.
- done, output, 1, one-cycle pulse when ACK_BYTE is received.
- fail, output, 1, one-cycle pulse when all attempts time out.
- attempt, output, $clog2(RETRANSMIT_COUNT+2), attempts made for the current byte (1 = first send).

Behaviour:
- Constants: CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (217 at defaults); TIMEOUT_CLKS = CLK_FREQ/1000*ACK_TIMEOUT.
- Reset values: ready=1, tx=1, done=0, fail=0, attempt=0, state IDLE, all counters 0.
- Reset mid-frame drives tx=1 on the next edge; the partially sent frame is abandoned.
- rx passes through a 2-flop synchroniser before any use.
- IDLE:
  - send&ready → latch data_in, attempt=1, ready=0, go to TX_START on the next cycle.
  - send while ready=0 is ignored.
- TX_START: tx=0 for CLKS_PER_BIT cycles → TX_DATA.
- TX_DATA: send DATA_WIDTH bits LSB first, each held CLKS_PER_BIT cycles; 3-bit index → TX_STOP.
- TX_STOP: tx=1 for CLKS_PER_BIT cycles → WAIT_ACK. Timeout counter clears on entry.
- WAIT_ACK:
  - Receiver is enabled only in this state. It detects a falling edge on synchronised rx, re-checks low at mid start bit (CLKS_PER_BIT/2), then samples each data bit at mid-bit and checks the stop bit.
  - Glitch start (rx high at mid start bit) → return to hunting.
  - Byte==ACK_BYTE with stop bit 1 → done=1 for one cycle, ready=1, IDLE.
  - Any other byte, or a bad stop bit → discarded; keep waiting; timeout keeps running.
  - Timeout reached with attempt ≤ RETRANSMIT_COUNT → attempt+1, resend the latched byte via TX_START.
  - Timeout reached with attempt = RETRANSMIT_COUNT+1 → fail=1 for one cycle, ready=1, IDLE.
  - ACK completing on the same cycle as the timeout → ACK wins, done asserted.
- Any rx activity outside WAIT_ACK is ignored.
- Frame duration = (DATA_WIDTH+2)*CLKS_PER_BIT cycles exactly.
- attempt holds its last value in IDLE until the next accepted send.
- done and fail are never asserted together.

Decomposition:
- Shared package ext_com_pkg holds:
  - state enum sender_state_t {IDLE, TX_START, TX_DATA, TX_STOP, WAIT_ACK};
  - UART_ACK constant (8'b11001100);
  - helper function clks_per_bit(clk_freq, baud).
- One sub-module, uart_byte_rx: synchroniser plus deserialiser with enable, byte_valid and byte_data outputs. It is reused by the receive-side block.
- TX serialiser and the control FSM stay in uart_ack_sender.

Test Plan:
- Single byte, prompt ACK:
  - Stimulus: reset, send data_in=8'h05; after stop bit and 100 clk, drive 8'hCC on rx.
  - tx frame is 0,1,0,1,0,0,0,0,0,1 with 217 clk per bit.
  - done pulses once, attempt=1, ready returns to 1.
- Wrong byte then ACK:
  - Stimulus: reply 8'h3B, then 8'hCC within the timeout.
  - First byte ignored; done after the second byte; no retransmission; attempt=1.
- Retry then success:
  - Stimulus: override ACK_TIMEOUT so TIMEOUT_CLKS=5000; no reply to the first frame; ACK after the second frame.
  - tx repeats the identical frame; done pulses; attempt=2.
- Exhaustion:
  - Stimulus: no reply at all, RETRANSMIT_COUNT=5.
  - Exactly 6 frames on tx, then fail pulses once; attempt=6; done stays 0.
- Busy/reset:
  - Stimulus: send 8'hA5, pulse send again mid-TX_DATA, then assert rst mid-frame.
  - Second send ignored; tx=1 one cycle after rst; ready=1, attempt=0.
  - A fresh send after reset yields a clean frame.
- Noise:
  - Stimulus: during WAIT_ACK, a 50-clk low glitch on rx, then a valid ACK.
  - Glitch rejected; done after the valid ACK.
